// File: rtl/note_scheduler.sv
// note_scheduler: owns the pool of falling note blocks. Accepts spawn and
// strike requests while idle, sweeps every slot once per video frame to move
// notes down the screen (retiring those that fall off), and answers
// registered per-pixel "is a note here" queries for the colour mux.
//
// Handshake: a spawn or strike transfers on a rising clk edge where its
// valid and ready are both high. The requester holds valid and payload
// stable until then. Ready may drop at any time (frame sweep, table full,
// or strike taking precedence) and a held request simply waits.
module note_scheduler #(
    parameter int NUM_SLOTS    = 8,
    parameter int LANES        = 4,
    parameter int LANE_W       = 160,
    parameter int LANE_MARGIN  = 20,
    parameter int NOTE_H       = 20,
    parameter int SPEED        = 2,
    parameter int VIDEO_HEIGHT = 480,
    parameter int HIT_Y        = 400,
    parameter int HIT_WIN      = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       screenEnd,
    input  logic       spawn_valid,
    input  logic [1:0] spawn_lane,
    output logic       spawn_ready,
    input  logic       strike_valid,
    input  logic [1:0] strike_lane,
    output logic       strike_ready,
    output logic       hit_pulse,
    output logic       empty_pulse,
    output logic       miss_pulse,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic       note_pixel,
    output logic [1:0] pixel_lane,
    output logic [3:0] active_count
);
    localparam int IDX_W = $clog2(NUM_SLOTS);

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    // FSM state is kept in a named enum so checkers can bind to it directly
    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] upd_idx;

    logic             screen_end_q;
    logic             frame_tick;

    logic [NUM_SLOTS-1:0] slot_valid;
    logic [1:0]           slot_lane [NUM_SLOTS];
    logic [8:0]           slot_ny   [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] valid_d;
    logic [1:0]           lane_d    [NUM_SLOTS];
    logic [8:0]           ny_d      [NUM_SLOTS];
    logic                 hit_d;
    logic                 empty_d;
    logic                 miss_d;
    logic [3:0]           count_d;

    logic                 strike_hit;
    logic [IDX_W-1:0]     strike_idx;
    logic [IDX_W-1:0]     free_idx;
    logic [9:0]           upd_sum;

    logic                 pix_hit;
    logic [1:0]           pix_lane;

    assign frame_tick = screenEnd & ~screen_end_q;

    // FSM state register and sweep index
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            upd_idx <= '0;
        end else begin
            state_q <= state_d;
            upd_idx <= (state_q == UPDATE) ? upd_idx + 1'b1 : '0;
        end
    end

    // FSM next state: a frame tick starts a sweep, the last slot ends it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_tick) state_d = UPDATE;
            UPDATE:  if (upd_idx == IDX_W'(NUM_SLOTS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: requests are only taken while idle; strike wins over spawn
    always_comb begin
        spawn_ready  = 1'b0;
        strike_ready = 1'b0;
        if (!reset && state_q == IDLE) begin
            strike_ready = 1'b1;
            spawn_ready  = ~(&slot_valid) & ~strike_valid;
        end
    end

    // Lowest-index slot in the struck lane whose top edge sits in the window
    always_comb begin
        strike_hit = 1'b0;
        strike_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_valid[i] && slot_lane[i] == strike_lane &&
                {1'b0, slot_ny[i]} >= 10'(HIT_Y) &&
                {1'b0, slot_ny[i]} < 10'(HIT_Y + HIT_WIN)) begin
                strike_hit = 1'b1;
                strike_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index free slot for a new note
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_valid[i]) free_idx = IDX_W'(i);
        end
    end

    // Slot table next state: strike/spawn while idle, one slot per sweep cycle
    always_comb begin
        valid_d = slot_valid;
        lane_d  = slot_lane;
        ny_d    = slot_ny;
        hit_d   = 1'b0;
        empty_d = 1'b0;
        miss_d  = 1'b0;
        upd_sum = {1'b0, slot_ny[upd_idx]} + 10'(SPEED);
        if (state_q == IDLE) begin
            if (strike_valid && strike_ready) begin
                if (strike_hit) begin
                    valid_d[strike_idx] = 1'b0;
                    hit_d               = 1'b1;
                end else begin
                    empty_d = 1'b1;
                end
            end
            if (spawn_valid && spawn_ready) begin
                valid_d[free_idx] = 1'b1;
                lane_d[free_idx]  = spawn_lane;
                ny_d[free_idx]    = '0;
            end
        end else if (slot_valid[upd_idx]) begin
            if (upd_sum >= 10'(VIDEO_HEIGHT)) begin
                valid_d[upd_idx] = 1'b0;
                miss_d           = 1'b1;
            end else begin
                ny_d[upd_idx] = upd_sum[8:0];
            end
        end
    end

    // Live-slot count of the table as it will be after this edge
    always_comb begin
        count_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            count_d = count_d + 4'(valid_d[i]);
        end
    end

    // Pixel hit test: lowest matching slot supplies the lane
    always_comb begin
        logic [10:0] x_lo;
        logic [10:0] x_hi;
        logic [9:0]  y_hi;
        pix_hit  = 1'b0;
        pix_lane = '0;
        x_lo     = '0;
        x_hi     = '0;
        y_hi     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            x_lo = 11'(slot_lane[i]) * 11'(LANE_W) + 11'(LANE_MARGIN);
            x_hi = (11'(slot_lane[i]) + 11'd1) * 11'(LANE_W) - 11'(LANE_MARGIN);
            y_hi = {1'b0, slot_ny[i]} + 10'(NOTE_H);
            if (slot_valid[i] && int'(slot_lane[i]) < LANES &&
                {1'b0, x} >= x_lo && {1'b0, x} < x_hi &&
                y >= slot_ny[i] && {1'b0, y} < y_hi) begin
                pix_hit  = 1'b1;
                pix_lane = slot_lane[i];
            end
        end
    end

    // Slot table, status pulses, count and pixel outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            screen_end_q <= 1'b0;
            slot_valid   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_lane[i] <= '0;
                slot_ny[i]   <= '0;
            end
            hit_pulse    <= 1'b0;
            empty_pulse  <= 1'b0;
            miss_pulse   <= 1'b0;
            active_count <= '0;
            note_pixel   <= 1'b0;
            pixel_lane   <= '0;
        end else begin
            screen_end_q <= screenEnd;
            slot_valid   <= valid_d;
            slot_lane    <= lane_d;
            slot_ny      <= ny_d;
            hit_pulse    <= hit_d;
            empty_pulse  <= empty_d;
            miss_pulse   <= miss_d;
            active_count <= count_d;
            note_pixel   <= pix_hit;
            pixel_lane   <= pix_lane;
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: pixel geometry table, hand-written scenarios,
// then randomized traffic against a reference model of the note pool.
module tb_note_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       screenEnd;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic       spawn_ready;
    logic       strike_valid;
    logic [1:0] strike_lane;
    logic       strike_ready;
    logic       hit_pulse;
    logic       empty_pulse;
    logic       miss_pulse;
    logic [9:0] x;
    logic [8:0] y;
    logic       note_pixel;
    logic [1:0] pixel_lane;
    logic [3:0] active_count;

    always #5 clk = ~clk;

    note_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .screenEnd    (screenEnd),
        .spawn_valid  (spawn_valid),
        .spawn_lane   (spawn_lane),
        .spawn_ready  (spawn_ready),
        .strike_valid (strike_valid),
        .strike_lane  (strike_lane),
        .strike_ready (strike_ready),
        .hit_pulse    (hit_pulse),
        .empty_pulse  (empty_pulse),
        .miss_pulse   (miss_pulse),
        .x            (x),
        .y            (y),
        .note_pixel   (note_pixel),
        .pixel_lane   (pixel_lane),
        .active_count (active_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the note pool (plain integers)
    int m_valid [8];
    int m_lane  [8];
    int m_ny    [8];
    int m_sweep = -1;      // -1: idle, else slot the frame sweep handles next
    int m_prev_se = 0;
    int last_sr, last_tr;  // readies observed in the most recent cycle
    int miss_seen = 0;
    int hit_seen  = 0;

    typedef struct {
        int px;
        int py;
        int pix;
        int lane;
    } pix_vec_t;
    pix_vec_t vecs [12];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int live_notes();
        int c = 0;
        for (int i = 0; i < 8; i++) c += m_valid[i];
        return c;
    endfunction

    function automatic int covers(int s, int px, int py);
        int lo = m_lane[s] * 160 + 20;
        int hi = (m_lane[s] + 1) * 160 - 20;
        return (m_valid[s] != 0 && px >= lo && px < hi &&
                py >= m_ny[s] && py < m_ny[s] + 20) ? 1 : 0;
    endfunction

    task automatic set_idle();
        screenEnd    = 1'b0;
        spawn_valid  = 1'b0;
        spawn_lane   = 2'd0;
        strike_valid = 1'b0;
        strike_lane  = 2'd0;
    endtask

    // One clock: check readies, advance the model, check registered outputs.
    // Called at posedge+1 with inputs already set; returns at next posedge+1.
    task automatic cycle();
        int e_hit, e_empty, e_miss, e_pix, e_lane, tick, k;
        #1;
        last_sr = int'(spawn_ready);
        last_tr = int'(strike_ready);
        check("strike_ready", last_tr, (!reset && m_sweep < 0) ? 1 : 0);
        check("spawn_ready", last_sr,
              (!reset && m_sweep < 0 && live_notes() < 8 && !strike_valid) ? 1 : 0);
        e_pix = 0; e_lane = 0; e_hit = 0; e_empty = 0; e_miss = 0;
        for (int i = 7; i >= 0; i--) begin
            if (covers(i, int'(x), int'(y)) != 0) begin
                e_pix  = 1;
                e_lane = m_lane[i];
            end
        end
        if (reset) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
            m_sweep = -1; m_prev_se = 0; e_pix = 0; e_lane = 0;
        end else begin
            tick = (screenEnd && m_prev_se == 0) ? 1 : 0;
            m_prev_se = int'(screenEnd);
            if (m_sweep < 0) begin
                if (strike_valid) begin
                    k = -1;
                    for (int i = 7; i >= 0; i--)
                        if (m_valid[i] != 0 && m_lane[i] == int'(strike_lane) &&
                            m_ny[i] >= 400 && m_ny[i] < 440) k = i;
                    if (k >= 0) begin m_valid[k] = 0; e_hit = 1; end
                    else e_empty = 1;
                end else if (spawn_valid && live_notes() < 8) begin
                    k = -1;
                    for (int i = 7; i >= 0; i--) if (m_valid[i] == 0) k = i;
                    m_valid[k] = 1; m_lane[k] = int'(spawn_lane); m_ny[k] = 0;
                end
                if (tick != 0) m_sweep = 0;
            end else begin
                if (m_valid[m_sweep] != 0) begin
                    if (m_ny[m_sweep] + 2 >= 480) begin
                        m_valid[m_sweep] = 0; e_miss = 1;
                    end else m_ny[m_sweep] += 2;
                end
                m_sweep++;
                if (m_sweep == 8) m_sweep = -1;
            end
        end
        @(posedge clk); #1;
        if (miss_pulse) miss_seen++;
        if (hit_pulse) hit_seen++;
        check("hit_pulse", int'(hit_pulse), e_hit);
        check("empty_pulse", int'(empty_pulse), e_empty);
        check("miss_pulse", int'(miss_pulse), e_miss);
        check("active_count", int'(active_count), live_notes());
        check("note_pixel", int'(note_pixel), e_pix);
        check("pixel_lane", int'(pixel_lane), e_lane);
    endtask

    // One frame: rising screenEnd, then enough idle cycles to finish the sweep
    task automatic frame();
        screenEnd = 1'b1; cycle();
        screenEnd = 1'b0;
        repeat (9) cycle();
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1; cycle();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{340, 5, 1, 2};
        vecs[1]  = '{330, 5, 0, 0};
        vecs[2]  = '{339, 5, 0, 0};
        vecs[3]  = '{459, 19, 1, 2};
        vecs[4]  = '{460, 5, 0, 0};
        vecs[5]  = '{340, 20, 0, 0};
        vecs[6]  = '{20, 0, 1, 0};
        vecs[7]  = '{19, 0, 0, 0};
        vecs[8]  = '{139, 10, 1, 0};
        vecs[9]  = '{140, 10, 0, 0};
        vecs[10] = '{600, 3, 0, 0};
        vecs[11] = '{400, 0, 1, 2};

        for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_lane[i] = 0; m_ny[i] = 0; end
        set_idle();
        x = '0; y = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_spawn_ready", int'(spawn_ready), 0);
        check("rst_strike_ready", int'(strike_ready), 0);
        check("rst_count", int'(active_count), 0);
        check("rst_note_pixel", int'(note_pixel), 0);
        check("rst_pulses", int'({hit_pulse, empty_pulse, miss_pulse}), 0);
        cycle();
        reset = 1'b0;

        // Pixel geometry: lane-2 and lane-0 notes at the top of the screen
        spawn_valid = 1'b1; spawn_lane = 2'd2; cycle();
        check("spawn_count1", int'(active_count), 1);
        spawn_lane = 2'd0; cycle();
        spawn_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            x = 10'(vecs[i].px); y = 9'(vecs[i].py);
            cycle();
            check($sformatf("vec%0d_pixel", i), int'(note_pixel), vecs[i].pix);
            check($sformatf("vec%0d_lane", i), int'(pixel_lane), vecs[i].lane);
        end
        x = '0; y = '0;

        // Fill the pool, stall the ninth request, release it after the retire
        do_reset();
        for (int i = 0; i < 8; i++) begin
            spawn_valid = 1'b1; spawn_lane = 2'(i % 4); cycle();
        end
        cycle();
        check("full_ready", last_sr, 0);
        check("full_count", int'(active_count), 8);
        miss_seen = 0;
        for (int f = 0; f < 240; f++) frame();
        check("full_misses", miss_seen, 8);
        check("ninth_accepted", int'(active_count), 1);
        spawn_valid = 1'b0;

        // Single note retires exactly once on its 240th sweep
        do_reset();
        spawn_valid = 1'b1; spawn_lane = 2'd3; cycle();
        spawn_valid = 1'b0;
        miss_seen = 0;
        for (int f = 0; f < 239; f++) frame();
        check("miss_early", miss_seen, 0);
        frame();
        check("miss_once", miss_seen, 1);
        check("miss_freed", int'(active_count), 0);

        // Lane-0 note to ny=400, lane-1 note to ny=100; wrong strikes are empty
        do_reset();
        spawn_valid = 1'b1; spawn_lane = 2'd0; cycle();
        spawn_valid = 1'b0;
        for (int f = 0; f < 150; f++) frame();
        spawn_valid = 1'b1; spawn_lane = 2'd1; cycle();
        spawn_valid = 1'b0;
        for (int f = 0; f < 50; f++) frame();
        x = 10'd50; y = 9'd400; cycle();
        check("ny400_pixel", int'(note_pixel), 1);
        y = 9'd399; cycle();
        check("ny399_pixel", int'(note_pixel), 0);
        strike_valid = 1'b1; strike_lane = 2'd1; cycle();
        check("empty_lane1", int'(empty_pulse), 1);
        check("empty_count", int'(active_count), 2);
        strike_lane = 2'd0; cycle();
        check("hit_lane0", int'(hit_pulse), 1);
        check("hit_count", int'(active_count), 1);
        strike_valid = 1'b0;

        // Spawn and strike together: strike first, spawn the next cycle
        spawn_valid = 1'b1; spawn_lane = 2'd2;
        strike_valid = 1'b1; strike_lane = 2'd3; cycle();
        check("both_spawn_ready", last_sr, 0);
        check("both_empty", int'(empty_pulse), 1);
        strike_valid = 1'b0; cycle();
        check("both_spawn_later", int'(active_count), 2);
        spawn_valid = 1'b0;

        // Reset in the middle of a sweep
        screenEnd = 1'b1; cycle();
        screenEnd = 1'b0; cycle(); cycle();
        reset = 1'b1; cycle();
        reset = 1'b0; cycle();
        check("post_rst_ready", last_sr, 1);
        check("post_rst_count", int'(active_count), 0);

        // Randomized traffic against the model
        do_reset();
        begin
            int frame_gap = 0;
            int se_left = 0;
            for (int c = 0; c < 9000; c++) begin
                if (se_left > 0) begin screenEnd = 1'b1; se_left--; end
                else begin
                    screenEnd = 1'b0;
                    frame_gap++;
                    if (frame_gap >= $urandom_range(14, 24)) begin
                        frame_gap = 0; se_left = $urandom_range(1, 3);
                    end
                end
                spawn_valid  = ($urandom_range(0, 3) == 0);
                spawn_lane   = 2'($urandom_range(0, 3));
                strike_valid = ($urandom_range(0, 7) == 0);
                strike_lane  = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) begin
                    int s = $urandom_range(0, 7);
                    int px = m_lane[s] * 160 + $urandom_range(0, 159);
                    int py = m_ny[s] + $urandom_range(0, 24) - 2;
                    if (py < 0) py = 0;
                    if (py > 479) py = 479;
                    x = 10'(px); y = 9'(py);
                end else begin
                    x = 10'($urandom_range(0, 639));
                    y = 9'($urandom_range(0, 479));
                end
                cycle();
            end
        end
        set_idle();
        check("random_hits_seen", (hit_seen > 0) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
